// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: counter control codes, scheduler command and state encodings.
package counter_sched_pkg;
  localparam logic [7:0] ALU_NOP             = 8'h00;
  localparam logic [7:0] ALU_COUNTER         = 8'h01;
  localparam logic [7:0] ALU_COUNTER_AUTO    = 8'h02;
  localparam logic [7:0] ALU_COUNTER_TRIGGER = 8'h03;
  localparam logic [7:0] ALU_COUNTER_RESET   = 8'h04;
  localparam logic [7:0] ALU_COUNTER_OUT     = 8'h05;
  localparam logic [2:0] CSCHED_CMD_SET      = 3'd0;
  localparam logic [2:0] CSCHED_CMD_AUTO     = 3'd1;
  localparam logic [2:0] CSCHED_CMD_TRIGGER  = 3'd2;
  localparam logic [2:0] CSCHED_CMD_RESET    = 3'd3;
  localparam logic [2:0] CSCHED_CMD_READ     = 3'd4;
  typedef enum logic [1:0] {CSCHED_IDLE, CSCHED_DRIVE, CSCHED_GAP} csched_state_e;
  function automatic logic [7:0] csched_map(input logic [2:0] cmd);
    return cmd == CSCHED_CMD_SET     ? ALU_COUNTER :
           cmd == CSCHED_CMD_AUTO    ? ALU_COUNTER_AUTO :
           cmd == CSCHED_CMD_TRIGGER ? ALU_COUNTER_TRIGGER :
           cmd == CSCHED_CMD_RESET   ? ALU_COUNTER_RESET :
           cmd == CSCHED_CMD_READ    ? ALU_COUNTER_OUT : ALU_NOP;
  endfunction
endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant over eligible requesters; pointer moves past each winner.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    elig,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_any
);
  logic [ID_W-1:0] ptr_q, ptr_d, idx;
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % N);
      if (!gnt_any && req[idx] && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end
  assign gnt   = gnt_any ? N'(1) << gnt_id : '0;
  assign ptr_d = !advance ? ptr_q : (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
  always_ff @(posedge clk) ptr_q <= !rst_n ? '0 : ptr_d;
endmodule

// File: rtl/counter_sched.sv
// counter_sched: shares one counter among N_REQ requesters with round-robin, lock,
// a one-cycle DRIVE per command and a mandatory idle cycle after TRIGGER.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 2,
  parameter int ID_W       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [3*N_REQ-1:0]          req_cmd,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_dr0,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_dr1,
  input  logic [N_REQ-1:0]            req_lock,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       cr_out,
  output logic [DATA_WIDTH-1:0]       dr0_out,
  output logic [DATA_WIDTH-1:0]       dr1_out,
  input  logic [DATA_WIDTH-1:0]       ctr_result,
  input  logic [DATA_WIDTH-1:0]       ctr_addition,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_flag,
  output logic                        rsp_err
);
  csched_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] cr_q, cr_d, dr0_q, dr0_d, dr1_q, dr1_d, data_q, data_d;
  logic [2:0] cmd_q, cmd_d, win_cmd;
  logic [ID_W-1:0] id_q, id_d, owner_q, owner_d, rid_q, rid_d, gnt_id;
  logic lock_q, lock_d, rv_q, rv_d, flag_q, flag_d, err_q, err_d, gnt_any, accept;
  logic [N_REQ-1:0] gnt, elig;
  assign elig    = lock_q ? N_REQ'(1) << owner_q : '1;
  assign accept  = state_q == CSCHED_IDLE && gnt_any;
  assign win_cmd = req_cmd[int'(gnt_id)*3 +: 3];
  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .elig(elig), .advance(accept),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_any(gnt_any)
  );
  assign req_ready = accept ? gnt : '0;
  always_comb begin
    state_d = state_q;
    cr_d    = DATA_WIDTH'(ALU_NOP);
    dr0_d   = dr0_q;
    dr1_d   = dr1_q;
    cmd_d   = cmd_q;
    id_d    = id_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    rv_d    = 1'b0;
    rid_d   = '0;
    data_d  = '0;
    flag_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      // a winner always satisfies the lock mask, so its lock bit is the new lock state
      lock_d  = req_lock[gnt_id];
      owner_d = gnt_id;
      id_d    = gnt_id;
      if (win_cmd > CSCHED_CMD_READ) begin
        rv_d  = 1'b1;
        rid_d = gnt_id;
        err_d = 1'b1;
      end else begin
        state_d = CSCHED_DRIVE;
        cmd_d   = win_cmd;
        cr_d    = DATA_WIDTH'(csched_map(win_cmd));
        dr0_d   = req_dr0[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        dr1_d   = req_dr1[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state_q == CSCHED_DRIVE) begin
      state_d = cmd_q == CSCHED_CMD_TRIGGER ? CSCHED_GAP : CSCHED_IDLE;
      rv_d    = 1'b1;
      rid_d   = id_q;
      data_d  = cmd_q == CSCHED_CMD_READ ? ctr_result : '0;
      flag_d  = cmd_q == CSCHED_CMD_READ && ctr_addition[0];
    end
    if (state_q == CSCHED_GAP) state_d = CSCHED_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CSCHED_IDLE;
      cr_q    <= DATA_WIDTH'(ALU_NOP);
      dr0_q   <= '0;
      dr1_q   <= '0;
      cmd_q   <= '0;
      id_q    <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      dr0_q   <= dr0_d;
      dr1_q   <= dr1_d;
      cmd_q   <= cmd_d;
      id_q    <= id_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end
  assign cr_out    = cr_q;
  assign dr0_out   = dr0_q;
  assign dr1_out   = dr1_q;
  assign rsp_valid = rv_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = data_q;
  assign rsp_flag  = flag_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed vector table plus hand sequences for trigger spacing,
// round-robin and lock ownership.
module tb_counter_sched;
  localparam logic [7:0] NOP = 8'h00, CNT = 8'h01, TRG = 8'h03, OUT = 8'h05;
  localparam logic [2:0] C_SET = 3'd0, C_AUTO = 3'd1, C_TRG = 3'd2, C_RD = 3'd4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [5:0] req_cmd = '0;
  logic [15:0] req_dr0 = '0, req_dr1 = '0;
  logic [7:0] ctr_result = '0, ctr_addition = '0, cr_out, dr0_out, dr1_out, rsp_data;
  logic rsp_valid, rsp_id, rsp_flag, rsp_err;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  counter_sched #(.DATA_WIDTH(8), .N_REQ(2), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_dr0(req_dr0), .req_dr1(req_dr1), .req_lock(req_lock), .req_ready(req_ready),
    .cr_out(cr_out), .dr0_out(dr0_out), .dr1_out(dr1_out), .ctr_result(ctr_result),
    .ctr_addition(ctr_addition), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic [1:0] v, input logic [5:0] c, input logic [1:0] l);
    @(negedge clk);
    req_valid = v;
    req_cmd   = c;
    req_lock  = l;
    #1;
  endtask
  typedef struct {
    logic chk; logic rst_n; logic [1:0] valid; logic [5:0] cmd;
    logic [15:0] dr0, dr1; logic [1:0] lock; logic [7:0] res, add;
    logic [1:0] ready; logic [7:0] cr, d0, d1; logic rv, rid;
    logic [7:0] rdata; logic rflag, rerr;
  } vec_t;
  vec_t v[14];
  logic [7:0] exp_cr[5];
  logic exp_r1[5];
  logic gq[$], rq[$];
  logic [2:0] seq[3];
  logic lk[3];
  int k, g0, rd_at;
  initial begin
    v[0]  = '{0, 0, 2'b11, {C_SET, C_SET}, 0, 0, 0, 0, 0, 2'b00, NOP, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{1, 0, 2'b11, {C_SET, C_SET}, 0, 0, 0, 0, 0, 2'b01, NOP, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{1, 1, 2'b11, {C_RD, C_SET}, 16'h0005, 16'h000A, 0, 0, 0, 2'b01, NOP, 0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{1, 1, 2'b10, {C_RD, C_SET}, 16'h0005, 16'h000A, 0, 0, 0, 2'b00, CNT, 8'h05, 8'h0A, 0, 0, 0, 0, 0};
    v[4]  = '{1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, NOP, 8'h05, 8'h0A, 1, 0, 0, 0, 0};
    v[5]  = '{1, 1, 2'b01, {C_SET, C_RD}, 16'h0011, 16'h0022, 0, 0, 0, 2'b01, NOP, 8'h05, 8'h0A, 0, 0, 0, 0, 0};
    v[6]  = '{1, 1, 2'b00, 0, 0, 0, 0, 8'h07, 8'h81, 2'b00, OUT, 8'h11, 8'h22, 0, 0, 0, 0, 0};
    v[7]  = '{1, 1, 2'b00, 0, 0, 0, 0, 8'h99, 8'h00, 2'b00, NOP, 8'h11, 8'h22, 1, 0, 8'h07, 1, 0};
    v[8]  = '{1, 1, 2'b10, {3'd6, C_SET}, 0, 0, 0, 0, 0, 2'b10, NOP, 8'h11, 8'h22, 0, 0, 0, 0, 0};
    v[9]  = '{1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, NOP, 8'h11, 8'h22, 1, 1, 0, 0, 1};
    v[10] = '{1, 1, 2'b01, {C_SET, C_SET}, 16'h0033, 16'h0044, 0, 0, 0, 2'b01, NOP, 8'h11, 8'h22, 0, 0, 0, 0, 0};
    v[11] = '{1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, CNT, 8'h33, 8'h44, 0, 0, 0, 0, 0};
    v[12] = '{1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, NOP, 0, 0, 0, 0, 0, 0, 0};
    v[13] = '{1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, NOP, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n; req_valid = v[i].valid; req_cmd = v[i].cmd;
      req_dr0 = v[i].dr0; req_dr1 = v[i].dr1; req_lock = v[i].lock;
      ctr_result = v[i].res; ctr_addition = v[i].add;
      #1;
      if (v[i].chk) begin
        chk($sformatf("v%0d.ready", i), req_ready, v[i].ready);
        chk($sformatf("v%0d.cr", i), cr_out, v[i].cr);
        chk($sformatf("v%0d.dr0", i), dr0_out, v[i].d0);
        chk($sformatf("v%0d.dr1", i), dr1_out, v[i].d1);
        chk($sformatf("v%0d.rsp_valid", i), rsp_valid, v[i].rv);
        chk($sformatf("v%0d.rsp_id", i), rsp_id, v[i].rid);
        chk($sformatf("v%0d.rsp_data", i), rsp_data, v[i].rdata);
        chk($sformatf("v%0d.rsp_flag", i), rsp_flag, v[i].rflag);
        chk($sformatf("v%0d.rsp_err", i), rsp_err, v[i].rerr);
      end
    end
    req_dr0 = '0; req_dr1 = '0; ctr_result = '0; ctr_addition = '0;
    // back-to-back TRIGGER from req1: accepts 3 cycles apart with a NOP gap
    exp_cr = '{NOP, TRG, NOP, NOP, TRG};
    exp_r1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      cyc(2'b10, {C_TRG, C_SET}, 2'b00);
      chk($sformatf("trg.cr%0d", c), cr_out, exp_cr[c]);
      chk($sformatf("trg.ready%0d", c), req_ready[1], exp_r1[c]);
      if (c == 2) chk("trg.rsp", {rsp_valid, rsp_id}, 2'b11);
    end
    repeat (3) cyc(2'b00, 6'd0, 2'b00);
    // round-robin with both requesters reading continuously
    for (int c = 0; c < 11; c++) begin
      cyc(c < 8 ? 2'b11 : 2'b00, {C_RD, C_RD}, 2'b00);
      if (req_ready != 2'b00) gq.push_back(req_ready[1]);
      if (rsp_valid) rq.push_back(rsp_id);
    end
    chk("rr.grants", gq.size(), 4);
    chk("rr.rsps", rq.size(), 4);
    foreach (gq[i]) chk($sformatf("rr.grant%0d", i), gq[i], i % 2);
    foreach (rq[i]) chk($sformatf("rr.rsp_id%0d", i), rq[i], i % 2);
    // move the pointer to req1 so the lock session starts on req1
    cyc(2'b01, {C_SET, C_SET}, 2'b00);
    chk("lock.pre", req_ready, 2'b01);
    repeat (2) cyc(2'b00, 6'd0, 2'b00);
    seq = '{C_AUTO, C_TRG, C_RD};
    lk  = '{1'b1, 1'b1, 1'b0};
    k = 0; g0 = -1; rd_at = -1;
    for (int n = 0; n < 30 && g0 < 0; n++) begin
      if (k < 3) cyc(2'b11, {seq[k], C_RD}, {lk[k], 1'b0});
      else cyc(2'b01, {C_SET, C_RD}, 2'b00);
      if (k < 3) chk($sformatf("lock.r0_%0d", n), req_ready[0], 1'b0);
      if (req_ready[0]) g0 = n;
      if (req_ready[1]) begin
        if (k == 2) rd_at = n;
        k++;
      end
    end
    chk("lock.req1_accepts", k, 3);
    chk("lock.req0_granted", g0 >= 0, 1'b1);
    chk("lock.req0_delay", g0 - rd_at, 2);
    repeat (3) cyc(2'b00, 6'd0, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
